// File: rtl/state_trace_monitor.sv
// Observer for the 3-bit state-code stream of the 7-state sequence FSM: entry counters, dwell/stuck,
// illegal-code and 0->1->2->0 pattern detection. Define STATE_TRACE_HIST_EN to add the hist output.
module state_trace_monitor #(
    parameter int CW        = 8,
    parameter int DWELL_W   = 6,
    parameter int DWELL_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic [2:0]    state_in,
    input  logic [2:0]    sel,
    output logic [CW-1:0] count_out,
    output logic [2:0]    cur_state,
    output logic          hit,
    output logic          stuck,
    output logic          illegal
`ifdef STATE_TRACE_HIST_EN
    ,
    output logic [11:0]   hist
`endif
);

    typedef enum logic [1:0] {P_IDLE, P_0, P_01, P_012} pat_t;

    localparam logic [2:0]         ILLEGAL_CODE = 3'd7;
    localparam logic [CW-1:0]      CNT_MAX      = '1;
    localparam logic [DWELL_W-1:0] DWELL_SAT    = '1;
    localparam logic [DWELL_W-1:0] DWELL_LIM    = DWELL_W'(DWELL_MAX);

    logic [CW-1:0]      cnt [7];
    logic               prev_valid;
    logic [DWELL_W-1:0] dwell;
    pat_t               pattern;

    logic               entry;
    logic [DWELL_W-1:0] dwell_next;
    pat_t               pattern_next;
    logic               hit_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        entry        = !prev_valid || (state_in != cur_state);
        dwell_next   = dwell;
        pattern_next = pattern;
        hit_next     = 1'b0;

        if (entry)
            dwell_next = DWELL_W'(1);
        else if (dwell != DWELL_SAT)
            dwell_next = dwell + DWELL_W'(1);

        // The matcher only moves on entries; code 7 falls through to P_IDLE as a breaking symbol.
        if (entry) begin
            pattern_next = P_IDLE;
            case (pattern)
                P_IDLE: if (state_in == 3'd0) pattern_next = P_0;
                P_0:    if (state_in == 3'd1) pattern_next = P_01;
                P_01: begin
                    if (state_in == 3'd2)      pattern_next = P_012;
                    else if (state_in == 3'd0) pattern_next = P_0;
                end
                P_012: begin
                    if (state_in == 3'd0) begin
                        pattern_next = P_0;
                        hit_next     = 1'b1;
                    end
                end
                default: pattern_next = P_IDLE;
            endcase
        end
    end

    always_comb begin
        count_out = '0;
        if (sel != ILLEGAL_CODE)
            count_out = cnt[sel];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < 7; i++) cnt[i] <= '0;
            cur_state  <= 3'd0;
            prev_valid <= 1'b0;
            dwell      <= '0;
            pattern    <= P_IDLE;
            hit        <= 1'b0;
            stuck      <= 1'b0;
            illegal    <= 1'b0;
`ifdef STATE_TRACE_HIST_EN
            hist       <= 12'h000;
`endif
        end else if (clear) begin
            for (int i = 0; i < 7; i++) cnt[i] <= '0;
            cur_state  <= 3'd0;
            prev_valid <= 1'b0;
            dwell      <= '0;
            pattern    <= P_IDLE;
            hit        <= 1'b0;
            stuck      <= 1'b0;
            illegal    <= 1'b0;
`ifdef STATE_TRACE_HIST_EN
            hist       <= 12'h000;
`endif
        end else if (en) begin
            cur_state  <= state_in;
            prev_valid <= 1'b1;
            dwell      <= dwell_next;
            pattern    <= pattern_next;
            hit        <= hit_next;
            if (dwell_next == DWELL_LIM)
                stuck <= 1'b1;
            if (state_in == ILLEGAL_CODE)
                illegal <= 1'b1;
            if (entry && state_in != ILLEGAL_CODE && cnt[state_in] != CNT_MAX)
                cnt[state_in] <= cnt[state_in] + CW'(1);
`ifdef STATE_TRACE_HIST_EN
            if (entry)
                hist <= {hist[8:0], state_in};
`endif
        end else begin
            hit <= 1'b0;
        end
    end

endmodule
